// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the MEM-stage core access and an
// external burst requester. The core owns the port until an external command is accepted.
module dmem_port_arbiter #(
    parameter int LEN_W    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             core_req,
    input  logic             core_we,
    input  logic [31:0]      core_addr,
    input  logic [3:0]       core_be,
    input  logic [31:0]      core_wd,
    output logic [31:0]      core_rd,
    output logic             core_stall,
    input  logic             ext_cmd_valid,
    output logic             ext_cmd_ready,
    input  logic             ext_cmd_we,
    input  logic [31:0]      ext_cmd_addr,
    input  logic [LEN_W-1:0] ext_cmd_len,
    output logic             ext_beat,
    input  logic [31:0]      ext_wdata,
    output logic             ext_rvalid,
    output logic [31:0]      ext_rdata,
    output logic             ext_busy,
    output logic             mem_we,
    output logic [31:0]      mem_a,
    output logic [3:0]       mem_be,
    output logic [31:0]      mem_wd,
    input  logic [31:0]      mem_rd
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    typedef enum logic {
        S_CORE,
        S_EXT
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [31:0]       addr_q, addr_d;
    logic              we_q, we_d;
    logic              ext_rvalid_q, ext_rvalid_d;
    logic [31:0]       ext_rdata_q, ext_rdata_d;

    assign core_rd    = mem_rd;
    assign ext_rvalid = ext_rvalid_q;
    assign ext_rdata  = ext_rdata_q;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        beat_cnt_d    = beat_cnt_q;
        len_d         = len_q;
        addr_d        = addr_q;
        we_d          = we_q;
        ext_rvalid_d  = 1'b0;
        ext_rdata_d   = ext_rdata_q;
        ext_cmd_ready = 1'b0;
        ext_beat      = 1'b0;
        ext_busy      = 1'b0;
        core_stall    = 1'b0;
        mem_we        = 1'b0;
        mem_a         = core_addr;
        mem_be        = core_be;
        mem_wd        = core_wd;

        if (state_q == S_CORE) begin
            mem_we        = core_req & core_we;
            // Gated by rst_n so a command is never acknowledged while reset is held.
            ext_cmd_ready = rst_n & ext_cmd_valid & (!core_req | (wait_cnt_q == WAIT_LIMIT));
            if (ext_cmd_ready) begin
                addr_d     = ext_cmd_addr & 32'hFFFF_FFFC;
                len_d      = ext_cmd_len;
                we_d       = ext_cmd_we;
                beat_cnt_d = '0;
                wait_cnt_d = '0;
                state_d    = S_EXT;
            end else if (ext_cmd_valid && core_req) begin
                if (wait_cnt_q != WAIT_LIMIT) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end else begin
                wait_cnt_d = '0;
            end
        end else begin
            ext_beat     = 1'b1;
            ext_busy     = 1'b1;
            core_stall   = core_req;
            mem_we       = we_q;
            mem_a        = addr_q + 32'({beat_cnt_q, 2'b00});
            mem_be       = 4'b1111;
            mem_wd       = ext_wdata;
            ext_rvalid_d = !we_q;
            if (!we_q) begin
                ext_rdata_d = mem_rd;
            end
            if (beat_cnt_q == len_q) begin
                state_d = S_CORE;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_CORE;
            wait_cnt_q   <= '0;
            beat_cnt_q   <= '0;
            len_q        <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            ext_rvalid_q <= 1'b0;
            ext_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            ext_rvalid_q <= ext_rvalid_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

endmodule
